microsequencer: RTL

Parametrised microprogrammed control sequencer, the next generation of the ALU datapath's control unit. It holds a writable control store and issues one 32-bit microword per cycle to the datapath. Next-address selection covers the existing sequential and conditional jumps, plus subroutine call/return on a hardware stack, a hardware loop counter and an explicit halt. It sits between the program loader and the ALU datapath, consuming the datapath's carry and zero flags.

---
 rtl/microsequencer_if.sv | 44 ++++
 rtl/microsequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer_if.sv
// Bus bundle between the microsequencer and its neighbours: run/flag
// inputs from the datapath, the program-loader write port, and the
// decoded microword plus status flowing back out to the datapath.
interface microsequencer_if #(
  parameter int AW = 6
);
  // Sequencing control and datapath flags
  logic          run;
  logic          carry;
  logic          zero;

  // Program-loader write port
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;

  // Microword fields issued to the datapath
  logic          ctl_ot;
  logic [3:0]    ctl_sbs;
  logic [3:0]    ctl_alu;
  logic [2:0]    ctl_shft;
  logic [3:0]    ctl_dest;
  logic [11:0]   ctl_const;

  // Status
  logic [AW-1:0] upc;
  logic          valid;
  logic          halted;
  logic          stack_err;

  // Loader/datapath side
  modport master (
    output run, carry, zero, prog_we, prog_addr, prog_data,
    input  ctl_ot, ctl_sbs, ctl_alu, ctl_shft, ctl_dest, ctl_const,
    input  upc, valid, halted, stack_err
  );

  // Sequencer side
  modport slave (
    input  run, carry, zero, prog_we, prog_addr, prog_data,
    output ctl_ot, ctl_sbs, ctl_alu, ctl_shft, ctl_dest, ctl_const,
    output upc, valid, halted, stack_err
  );
endinterface

// File: rtl/microsequencer.sv
// Microprogrammed control sequencer. A writable control store feeds a
// microinstruction register (mir) that drives the datapath one word per
// cycle. Next-address selection supports sequential flow, flag-conditional
// jumps, call/return on a small hardware stack, a loop counter and halt.
module microsequencer #(
  parameter int AW          = 6,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  microsequencer_if.slave   bus
);

  localparam int DEPTH = 2 ** AW;
  // Stack pointer counts entries in use, so it must hold 0..STACK_DEPTH.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  // Next-address codes held in mir[15:12]; 11..15 fall to the default arm.
  typedef enum logic [3:0] {
    NA_NXT   = 4'd0,
    NA_JMP   = 4'd1,
    NA_JC    = 4'd2,
    NA_JZ    = 4'd3,
    NA_JNC   = 4'd4,
    NA_JNZ   = 4'd5,
    NA_CALL  = 4'd6,
    NA_RET   = 4'd7,
    NA_LDCNT = 4'd8,
    NA_LOOP  = 4'd9,
    NA_HALT  = 4'd10
  } na_code_e;

  // Storage
  logic [31:0]      cstore_q [DEPTH];
  logic [AW-1:0]    stack_q  [STACK_DEPTH];

  // Sequencing state
  state_e           state_q, state_d;
  logic [31:0]      mir_q;
  logic [AW-1:0]    upc_q, upc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;

  // Combinational control
  logic             fetch_en;
  logic [AW-1:0]    fetch_addr;
  logic             push_en;
  logic             advance;
  logic [AW-1:0]    next_addr;
  na_code_e         code;
  logic [AW-1:0]    seq_addr;
  logic [AW-1:0]    jmp_addr;
  logic [AW-1:0]    top_addr;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  // Decode helpers; upc+1 wraps naturally at AW bits, which also makes
  // the pushed return address wrap.
  assign code     = na_code_e'(mir_q[15:12]);
  assign seq_addr = upc_q + AW'(1);
  assign jmp_addr = mir_q[AW-1:0];
  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign top_addr = stack_q[top_idx];

  // Control-store write port, open in every state.
  // NOTE: the store is a RAM, so it carries no reset; adding one would
  // block RAM inference and is not needed since the loader fills it.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      cstore_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Return-stack write port; only the pointer is reset, entries are not.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= seq_addr;
    end
  end

  // State register and mir fetch with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a same-address write therefore returns old
  // data to the fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      mir_q   <= '0;
      cnt_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      if (fetch_en) begin
        mir_q <= cstore_q[fetch_addr];
      end
    end
  end

  // Next-state, next-address and stack/counter updates.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    cnt_d      = cnt_q;
    sp_d       = sp_q;
    err_d      = err_q;
    fetch_en   = 1'b0;
    fetch_addr = upc_q;
    push_en    = 1'b0;
    advance    = 1'b1;
    next_addr  = seq_addr;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d    = S_RUN;
          upc_d      = '0;
          fetch_en   = 1'b1;
          fetch_addr = '0;
        end
      end

      S_RUN: begin
        if (bus.run) begin
          case (code)
            NA_NXT:  next_addr = seq_addr;
            NA_JMP:  next_addr = jmp_addr;
            NA_JC:   next_addr = bus.carry  ? jmp_addr : seq_addr;
            NA_JZ:   next_addr = bus.zero   ? jmp_addr : seq_addr;
            NA_JNC:  next_addr = !bus.carry ? jmp_addr : seq_addr;
            NA_JNZ:  next_addr = !bus.zero  ? jmp_addr : seq_addr;
            NA_CALL: begin
              if (sp_q == SP_FULL) begin
                err_d   = 1'b1;
                advance = 1'b0;
              end else begin
                push_en   = 1'b1;
                sp_d      = sp_q + SP_W'(1);
                next_addr = jmp_addr;
              end
            end
            NA_RET: begin
              if (sp_q == '0) begin
                err_d   = 1'b1;
                advance = 1'b0;
              end else begin
                sp_d      = sp_q - SP_W'(1);
                next_addr = top_addr;
              end
            end
            NA_LDCNT: begin
              cnt_d     = mir_q[CNT_W-1:0];
              next_addr = seq_addr;
            end
            NA_LOOP: begin
              if (cnt_q != '0) begin
                cnt_d     = cnt_q - CNT_W'(1);
                next_addr = jmp_addr;
              end else begin
                next_addr = seq_addr;
              end
            end
            // HALT and the undefined codes stop without flagging an error.
            default: advance = 1'b0;
          endcase

          if (advance) begin
            upc_d      = next_addr;
            fetch_en   = 1'b1;
            fetch_addr = next_addr;
          end else begin
            state_d = S_HALT;
          end
        end
      end

      // Halted: everything holds until reset.
      S_HALT: ;

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight from registered state.
  always_comb begin
    bus.ctl_ot    = mir_q[31];
    bus.ctl_sbs   = mir_q[30:27];
    bus.ctl_alu   = mir_q[26:23];
    bus.ctl_shft  = mir_q[22:20];
    bus.ctl_dest  = mir_q[19:16];
    bus.ctl_const = mir_q[11:0];
    bus.upc       = upc_q;
    bus.valid     = (state_q != S_IDLE);
    bus.halted    = (state_q == S_HALT);
    bus.stack_err = err_q;
  end

endmodule
